// File: rtl/ed25519_mul_io_buffer.sv
// Host I/O buffer around the Ed25519 base-point multiplier core:
// scalar word store, core kick/capture, and Qy result streaming.
module ed25519_mul_io_buffer #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        k_wr_en,
  input  logic [2:0]  k_wr_addr,
  input  logic [31:0] k_wr_data,
  input  logic        start,
  output logic        busy,
  output logic        err,
  output logic        qy_valid,
  input  logic        qy_ready,
  output logic [31:0] qy_data,
  output logic        qy_last,
  output logic        mul_ena,
  input  logic        mul_rdy,
  input  logic [2:0]  mul_k_addr,
  output logic [31:0] mul_k_din,
  input  logic [2:0]  mul_qy_addr,
  input  logic        mul_qy_wren,
  input  logic [31:0] mul_qy_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WBUSY,
    S_WDONE,
    S_STREAM
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  state_t state;
  state_t state_nx;

  logic [31:0]      kreg  [8];
  logic [31:0]      qyreg [8];
  logic [7:0]       qy_mask;
  logic [CNT_W-1:0] wdog;
  logic [2:0]       idx;

  logic             in_wait;
  logic             cap;
  logic [7:0]       cap_bit;
  logic [7:0]       mask_nx;
  logic [CNT_W-1:0] wdog_inc;
  logic             timeout;
  logic             xfer;
  logic             go;
  logic             done;
  logic [2:0]       idx_inc;
  logic [31:0]      word0;

  assign mul_k_din = kreg[mul_k_addr];

  assign in_wait  = (state == S_WBUSY) || (state == S_WDONE);
  assign cap      = in_wait && mul_qy_wren;
  assign cap_bit  = cap ? (8'd1 << mul_qy_addr) : 8'd0;
  assign mask_nx  = qy_mask | cap_bit;
  assign wdog_inc = wdog + 1'b1;
  assign timeout  = WD_EN && in_wait && (wdog_inc == TMO);
  assign xfer     = qy_valid && qy_ready;
  assign go       = (state == S_IDLE) && start;
  assign done     = (state == S_WDONE) && mul_rdy && !timeout;
  assign idx_inc  = idx + 3'd1;

  // a core write to word 0 may coincide with the rdy rise
  assign word0 = (cap && mul_qy_addr == 3'd0) ? mul_qy_dout : qyreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mul_ena  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_KICK;
      end
      S_KICK: begin
        mul_ena  = 1'b1;
        state_nx = S_WBUSY;
      end
      S_WBUSY: begin
        if (timeout)      state_nx = S_IDLE;
        else if (!mul_rdy) state_nx = S_WDONE;
      end
      S_WDONE: begin
        if (timeout)      state_nx = S_IDLE;
        else if (mul_rdy) state_nx = S_STREAM;
      end
      S_STREAM: begin
        if (xfer && idx == 3'd7) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        kreg[i]  <= '0;
        qyreg[i] <= '0;
      end
      qy_mask  <= '0;
      wdog     <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      qy_valid <= 1'b0;
      qy_data  <= '0;
      qy_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && k_wr_en)
        kreg[k_wr_addr] <= k_wr_data;

      if (cap)
        qyreg[mul_qy_addr] <= mul_qy_dout;

      if (go)          qy_mask <= '0;
      else if (cap)    qy_mask <= mask_nx;

      if (go)          wdog <= '0;
      else if (in_wait) wdog <= wdog_inc;

      if (go) begin
        busy <= 1'b1;
        err  <= 1'b0;
      end

      if (timeout) begin
        busy <= 1'b0;
        err  <= 1'b1;
      end

      if (done) begin
        if (mask_nx != 8'hFF) err <= 1'b1;
        idx      <= '0;
        qy_valid <= 1'b1;
        qy_data  <= word0;
        qy_last  <= 1'b0;
      end

      if (state == S_STREAM && xfer) begin
        if (idx == 3'd7) begin
          qy_valid <= 1'b0;
          qy_last  <= 1'b0;
          busy     <= 1'b0;
        end else begin
          idx     <= idx_inc;
          qy_data <= qyreg[idx_inc];
          qy_last <= (idx_inc == 3'd7);
        end
      end
    end
  end

endmodule

// File: doc/ed25519_mul_io_buffer.md
Name: ed25519_mul_io_buffer

Overview:
- Host-side front/back end for the Ed25519 base-point multiplier core; sits directly around it.
- Holds the 256-bit scalar k as 8x32 words and serves them to the core's word-addressed k read port.
- Kicks the core with a one-cycle enable and captures the 8 Qy result words the core writes back.
- Streams Qy to the host over a valid/ready channel, least-significant word first, with a watchdog and error flag.

Parameters:
- TIMEOUT_CYCLES, 2000000, max cycles allowed in WAIT_BUSY+WAIT_DONE before abort; 0 disables watchdog.
- CNT_W, 24, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- k_wr_en  in  1  host write strobe for scalar word
- k_wr_addr  in  3  scalar word index, 0 = least significant
- k_wr_data  in  32  scalar word
- start  in  1  one-cycle request to run a multiplication
- busy  out  1  high from accepted start until the last Qy word is accepted or an abort occurs
- err  out  1  sticky status of the last run; cleared on the next accepted start
- qy_valid  out  1  Qy word available
- qy_ready  in  1  host accepts Qy word
- qy_data  out  32  Qy word
- qy_last  out  1  high with word index 7
- mul_ena  out  1  to core enable
- mul_rdy  in  1  from core ready (high = idle/done)
- mul_k_addr  in  3  core scalar read address
- mul_k_din  out  32  scalar word to core
- mul_qy_addr  in  3  core result write address
- mul_qy_wren  in  1  core result write strobe
- mul_qy_dout  in  32  core result word

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, err=0, qy_valid=0, qy_last=0, qy_data=0, mul_ena=0. Scalar regs, Qy regs, qy_mask, watchdog and stream index all cleared to 0. Reset mid-run aborts with no output.
- mul_k_din = kreg[mul_k_addr], combinational, same cycle.
- Scalar writes:
  - k_wr_en in IDLE writes kreg[k_wr_addr].
  - Writes in any other state are ignored.
  - k_wr_en and start in the same IDLE cycle: the write lands first, and the run uses the new word.
- Qy capture: mul_qy_wren in WAIT_BUSY or WAIT_DONE writes qyreg[mul_qy_addr] and sets qy_mask[mul_qy_addr]. It is ignored in every other state.
- IDLE:
  - start=1 -> KICK; busy=1, err=0, qy_mask=0, watchdog=0.
  - start while busy is ignored.
- KICK: mul_ena=1 for exactly this one cycle -> WAIT_BUSY.
- WAIT_BUSY:
  - mul_rdy=0 -> WAIT_DONE.
  - Watchdog increments each cycle in WAIT_BUSY and WAIT_DONE.
- WAIT_DONE:
  - mul_rdy=1 -> STREAM; stream index=0.
  - If qy_mask != 8'hFF at this point, set err=1; streaming still proceeds.
- Watchdog abort: if TIMEOUT_CYCLES != 0 and the watchdog reaches TIMEOUT_CYCLES in either wait state -> IDLE; err=1, busy=0, nothing streamed.
- STREAM:
  - qy_valid=1, qy_data=qyreg[idx], qy_last=(idx==7). qy_data/qy_last are registered and stable while qy_valid=1 and qy_ready=0.
  - Transfer occurs when qy_valid && qy_ready; then idx increments.
  - Transfer with idx==7 -> IDLE. On the following cycle qy_valid=0 and busy=0.
  - Throughput is one word per cycle when qy_ready is held high: 8 cycles for 8 words.
- Latency:
  - start -> mul_ena: 1 cycle.
  - Core done (mul_rdy rise) -> first qy_valid: 1 cycle.
- qyreg persists after the run and is overwritten only by the next run's core writes.

Test Plan:
- Nominal run: load k words 0..7 = 32'h00000009,0,...,0; pulse start. Core model drops rdy 2 cycles after ena, reads all k_addr, writes qy[i]=32'hA0+i, raises rdy after 50 cycles. -> mul_ena high exactly 1 cycle; mul_k_din returns 9 at addr 0; stream outputs A0..A7 with qy_last on A7; err=0; busy falls the cycle after the last transfer.
- Backpressure: same run, qy_ready toggled 1,0,0,1,... -> each word held stable while stalled; exactly 8 transfers in order; no duplicates or drops.
- Incomplete result: core writes only addrs 0..6 before raising rdy. -> err=1; 8 words still streamed, word 7 = 0 after reset.
- Watchdog: TIMEOUT_CYCLES=100, core never drops rdy. -> after 100 cycles in WAIT_BUSY: err=1, busy=0, qy_valid never asserted; next start clears err.
- Ignored inputs: k_wr_en to addr 3 (value 32'hDEADBEEF) and start during WAIT_DONE. -> kreg[3] unchanged, no second mul_ena. Also k_wr_en to addr 0 with start in the same IDLE cycle -> core reads the new word at addr 0.
- Async reset mid-STREAM after 3 transfers. -> all outputs 0 immediately without a clock edge; a fresh run after reset completes normally.
